// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types for the sequential ALU.
//   alu_op_e    - 4-bit opcode encodings
//   alu_state_e - control FSM states
//   alu_flags_t - registered NZCV flag bundle
//   is_iter_op  - true for opcodes that run on the iterative mul/div datapath
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OpAdd   = 4'b0000,
    OpSub   = 4'b0001,
    OpAnd   = 4'b0010,
    OpOr    = 4'b0011,
    OpPassB = 4'b0100,
    OpSltu  = 4'b0101,
    OpSlt   = 4'b0110,
    OpXor   = 4'b0111,
    OpMul   = 4'b1000,
    OpDivu  = 4'b1001,
    OpRemu  = 4'b1010
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } alu_state_e;

  typedef struct packed {
    logic zero;
    logic negative;
    logic carry;
    logic overflow;
  } alu_flags_t;

  function automatic logic is_iter_op(input logic [3:0] op);
    return (op == OpMul) || (op == OpDivu) || (op == OpRemu);
  endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// alu_seq_muldiv: iterative shift-add multiplier / restoring divider, one step per cycle.
// Only compiled when ALU_SEQ_MULDIV_EN is defined.
//   i_clk, i_reset     - clock, synchronous active-high reset
//   i_start            - load operands and begin WIDTH iterations
//   i_op               - OpMul, OpDivu or OpRemu
//   i_a, i_b           - multiplicand/multiplier or dividend/divisor
//   o_last             - high during the final iteration
//   o_result           - value produced by the current iteration (valid with o_last)
`ifdef ALU_SEQ_MULDIV_EN
module alu_seq_muldiv
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  alu_op_e          i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_last,
  output logic [WIDTH-1:0] o_result
);

  localparam int unsigned CntW = $clog2(WIDTH);

  logic            r_busy;
  logic            r_is_mul;
  logic            r_is_rem;
  logic [CntW-1:0] r_cnt;
  // r_acc: running product (MUL) or partial remainder (DIV/REM)
  // r_x:   shifted multiplicand (MUL) or dividend shifting into quotient (DIV/REM)
  // r_y:   multiplier shifting right (MUL) or divisor (DIV/REM)
  logic [WIDTH-1:0] r_acc, r_x, r_y;

  logic [WIDTH-1:0] w_acc_next, w_x_next, w_y_next;
  logic [WIDTH:0]   w_shift, w_trial;

  always_comb begin
    w_shift = {r_acc, r_x[WIDTH-1]};
    w_trial = w_shift - {1'b0, r_y};
    if (r_is_mul) begin
      w_acc_next = r_y[0] ? (r_acc + r_x) : r_acc;
      w_x_next   = r_x << 1;
      w_y_next   = r_y >> 1;
    end else begin
      // Restore on borrow: keep the shifted remainder and shift in a 0 quotient bit.
      w_acc_next = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
      w_x_next   = {r_x[WIDTH-2:0], ~w_trial[WIDTH]};
      w_y_next   = r_y;
    end
  end

  assign o_last   = r_busy && (r_cnt == '0);
  assign o_result = (r_is_mul || r_is_rem) ? w_acc_next : w_x_next;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_busy   <= 1'b0;
      r_is_mul <= 1'b0;
      r_is_rem <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_x      <= '0;
      r_y      <= '0;
    end else if (i_start) begin
      r_busy   <= 1'b1;
      r_is_mul <= (i_op == OpMul);
      r_is_rem <= (i_op == OpRemu);
      r_cnt    <= CntW'(WIDTH - 1);
      r_acc    <= '0;
      r_x      <= i_a;
      r_y      <= i_b;
    end else if (r_busy) begin
      r_acc <= w_acc_next;
      r_x   <= w_x_next;
      r_y   <= w_y_next;
      r_cnt <= r_cnt - CntW'(1);
      if (r_cnt == '0) r_busy <= 1'b0;
    end
  end

endmodule
`endif

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered result and NZCV flags.
// Single-cycle ops complete on the accept edge; MUL/DIVU/REMU iterate for WIDTH cycles.
// Optional feature macro: ALU_SEQ_MULDIV_EN (enables MUL/DIVU/REMU; otherwise illegal).
//   clk, reset          - clock, synchronous active-high reset
//   InValid / InReady   - operand handshake (SrcA, SrcB, ALUControl)
//   OutValid / OutReady - result handshake
//   ALUResult           - registered result
//   Zero, Negative, Carry, Overflow - registered flags
//   Illegal             - high with the result when the accepted opcode has no datapath
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [3:0]       ALUControl,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             Negative,
  output logic             Carry,
  output logic             Overflow,
  output logic             Illegal
);

  alu_state_e       r_state, w_state_next;
  logic [WIDTH-1:0] r_result;
  alu_flags_t       r_flags;
  logic             r_illegal;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_iter;
  logic             w_illegal;
  logic             w_md_last;
  logic [WIDTH-1:0] w_md_result;
  logic [WIDTH:0]   w_sum, w_diff;
  logic [WIDTH-1:0] w_sc_result;
  logic             w_sc_carry, w_sc_ovf;
  alu_flags_t       w_sc_flags, w_md_flags;
  alu_op_e          w_op;

  assign w_op     = alu_op_e'(ALUControl);
  assign w_accept = InValid && w_in_ready;

`ifdef ALU_SEQ_MULDIV_EN
  assign w_iter    = is_iter_op(ALUControl);
  assign w_illegal = (ALUControl > 4'b1010);

  alu_seq_muldiv #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_start  (w_accept && w_iter),
    .i_op     (w_op),
    .i_a      (SrcA),
    .i_b      (SrcB),
    .o_last   (w_md_last),
    .o_result (w_md_result)
  );
`else
  // No iterative datapath: the whole 1xxx opcode space is illegal.
  assign w_iter      = 1'b0;
  assign w_illegal   = ALUControl[3];
  assign w_md_last   = 1'b0;
  assign w_md_result = '0;
`endif

  // Single-cycle datapath, evaluated on the operands being accepted.
  always_comb begin
    w_sum       = {1'b0, SrcA} + {1'b0, SrcB};
    w_diff      = {1'b0, SrcA} - {1'b0, SrcB};
    w_sc_result = '0;
    w_sc_carry  = 1'b0;
    w_sc_ovf    = 1'b0;
    case (w_op)
      OpAdd: begin
        w_sc_result = w_sum[WIDTH-1:0];
        w_sc_carry  = w_sum[WIDTH];
        w_sc_ovf    = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) && (w_sum[WIDTH-1] != SrcA[WIDTH-1]);
      end
      OpSub: begin
        w_sc_result = w_diff[WIDTH-1:0];
        w_sc_carry  = ~w_diff[WIDTH];  // not-borrow
        w_sc_ovf    = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) && (w_diff[WIDTH-1] != SrcA[WIDTH-1]);
      end
      OpAnd:   w_sc_result = SrcA & SrcB;
      OpOr:    w_sc_result = SrcA | SrcB;
      OpPassB: w_sc_result = SrcB;
      OpSltu:  w_sc_result = WIDTH'(SrcA < SrcB);
      OpSlt:   w_sc_result = WIDTH'($signed(SrcA) < $signed(SrcB));
      OpXor:   w_sc_result = SrcA ^ SrcB;
      default: w_sc_result = '0;  // illegal or iterative
    endcase
  end

  assign w_sc_flags = '{zero:     (w_sc_result == '0),
                        negative: w_sc_result[WIDTH-1],
                        carry:    w_sc_carry,
                        overflow: w_sc_ovf};
  assign w_md_flags = '{zero:     (w_md_result == '0),
                        negative: w_md_result[WIDTH-1],
                        carry:    1'b0,
                        overflow: 1'b0};

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  // FSM next state
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_next = w_iter ? StBusy : StDone;
      StBusy:  if (w_md_last) w_state_next = StDone;
      StDone:  if (OutReady) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    w_in_ready = (r_state == StIdle) && !reset;
    OutValid   = (r_state == StDone);
  end

  assign InReady = w_in_ready;

  // Result and flags only change on accept or the final iteration, so they hold through DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_result  <= '0;
      r_flags   <= '0;
      r_illegal <= 1'b0;
    end else if (w_accept && !w_iter) begin
      r_result  <= w_sc_result;
      r_flags   <= w_sc_flags;
      r_illegal <= w_illegal;
    end else if ((r_state == StBusy) && w_md_last) begin
      r_result  <= w_md_result;
      r_flags   <= w_md_flags;
      r_illegal <= 1'b0;
    end
  end

  assign ALUResult = r_result;
  assign Zero      = r_flags.zero;
  assign Negative  = r_flags.negative;
  assign Carry     = r_flags.carry;
  assign Overflow  = r_flags.overflow;
  assign Illegal   = r_illegal;

endmodule
